// File: rtl/fetch_sequencer.sv
// Fetch/branch sequencer: decodes branch and halt opcodes from the ROM word at
// pc and issues load/branch requests to an external program counter.
module fetch_sequencer #(
  parameter int rom_size    = 512,
  parameter int instr_width = 9,
  parameter int reg_width   = 8,
  localparam int PW         = $clog2(rom_size) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go,
  input  logic [PW-1:0]               go_addr,
  input  logic [PW-1:0]               pc,
  input  logic [instr_width-1:0]      instr,
  input  logic [instr_width-1:0]      operand,
  input  logic                        flag_we,
  input  logic                        flag_d,
  output logic                        start,
  output logic [PW-1:0]               start_addr,
  output logic                        branch,
  output logic                        taken,
  output logic signed [reg_width-1:0] target,
  output logic                        running,
  output logic                        done,
  output logic [15:0]                 instr_count
);

  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_BRF = 4'b1110;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic          flag_q, flag_nxt;
  logic [PW-1:0] halt_pc_q, halt_pc_d;
  logic [15:0]   instr_count_q, instr_count_d;

  logic [3:0] opcode;
  logic       is_hlt;

  assign opcode      = instr[instr_width-1:instr_width-4];
  assign is_hlt      = &instr;
  assign instr_count = instr_count_q;

  // Output decode: branch controls come straight from the current ROM words.
  always_comb begin
    start      = 1'b0;
    start_addr = '0;
    branch     = 1'b0;
    taken      = 1'b0;
    target     = '0;
    running    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      RUN: begin
        running = 1'b1;
        if (is_hlt) begin
          start      = 1'b1;
          start_addr = pc;
        end else if (opcode == OP_BR) begin
          branch = 1'b1;
          taken  = 1'b1;
          target = $signed(operand[reg_width-1:0]);
        end else if (opcode == OP_BRF) begin
          branch = 1'b1;
          taken  = flag_q;
          target = $signed(operand[reg_width-1:0]);
        end
      end
      HALT: begin
        start      = 1'b1;
        done       = 1'b1;
        start_addr = go ? go_addr : halt_pc_q;
      end
      default: begin
        start      = 1'b1;
        start_addr = go_addr;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    flag_nxt      = flag_q;
    halt_pc_d     = halt_pc_q;
    instr_count_d = instr_count_q;
    unique case (state_q)
      RUN: begin
        if (flag_we) flag_nxt = flag_d;
        if (is_hlt) begin
          state_d   = HALT;
          halt_pc_d = pc;
        end else if (instr_count_q != 16'hFFFF) begin
          instr_count_d = instr_count_q + 16'd1;
        end
      end
      IDLE, HALT: begin
        if (go) begin
          state_d       = RUN;
          instr_count_d = '0;
          flag_nxt      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      flag_q        <= 1'b0;
      halt_pc_q     <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      flag_q        <= flag_nxt;
      halt_pc_q     <= halt_pc_d;
      instr_count_q <= instr_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer with a queued scoreboard and an
// independent negedge monitor.
module tb_fetch_sequencer;

  logic              clk = 1'b0;
  logic              rst_n, go, flag_we, flag_d;
  logic [9:0]        go_addr, pc;
  logic [8:0]        instr, operand;
  logic              start, branch, taken, running, done;
  logic [9:0]        start_addr;
  logic signed [7:0] target;
  logic [15:0]       instr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [38:0] vec;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .go(go), .go_addr(go_addr), .pc(pc),
    .instr(instr), .operand(operand), .flag_we(flag_we), .flag_d(flag_d),
    .start(start), .start_addr(start_addr), .branch(branch), .taken(taken),
    .target(target), .running(running), .done(done), .instr_count(instr_count)
  );

  // Monitor: compares the whole output bundle against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [38:0] act;
      e   = sb_q.pop_front();
      act = {start, start_addr, branch, taken, target, running, done, instr_count};
      checks++;
      if (act !== e.vec) begin
        errors++;
        $display("FAIL %s: got st=%0b sa=%h br=%0b tk=%0b tg=%h run=%0b dn=%0b cnt=%h, want st=%0b sa=%h br=%0b tk=%0b tg=%h run=%0b dn=%0b cnt=%h",
                 e.name, act[38], act[37:28], act[27], act[26], act[25:18], act[17], act[16], act[15:0],
                 e.vec[38], e.vec[37:28], e.vec[27], e.vec[26], e.vec[25:18], e.vec[17], e.vec[16], e.vec[15:0]);
      end
    end
  end

  task automatic step(input string nm, input bit frc, input logic rn, g, input logic [9:0] ga, p,
                      input logic [8:0] ins, op, input logic fwe, fd,
                      input logic st, input logic [9:0] sa, input logic br, tk, input logic [7:0] tg,
                      input logic run, dn, input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    if (frc) begin
      force dut.instr_count_q = 16'hFFFE;
      #1;
      release dut.instr_count_q;
    end
    rst_n = rn; go = g; go_addr = ga; pc = p; instr = ins; operand = op;
    flag_we = fwe; flag_d = fd;
    e.name = nm;
    e.vec  = {st, sa, br, tk, tg, run, dn, cnt};
    sb_q.push_back(e);
  endtask

  localparam logic [8:0] NOP = 9'h000, BR = 9'h1A0, BRF = 9'h1C0, HLT = 9'h1FF;

  initial begin
    rst_n = 1'b0; go = 1'b0; go_addr = 10'h010; pc = '0; instr = NOP; operand = '0;
    flag_we = 1'b0; flag_d = 1'b0;
    repeat (2) @(posedge clk);
    //   name          frc rn go ga       pc       instr op      we fd | st sa      br tk tg     run dn cnt
    step("reset",       0, 0, 0, 10'h010, 10'h000, NOP, 9'h000, 0, 0,   1, 10'h010, 0, 0, 8'h00, 0, 0, 16'd0);
    step("idle_go",     0, 1, 1, 10'h010, 10'h000, NOP, 9'h000, 0, 0,   1, 10'h010, 0, 0, 8'h00, 0, 0, 16'd0);
    step("run_br",      0, 1, 0, 10'h010, 10'h010, BR,  9'h0FC, 0, 0,   0, 10'h000, 1, 1, 8'hFC, 1, 0, 16'd0);
    step("run_nop",     0, 1, 0, 10'h010, 10'h00C, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'd1);
    step("brf_nt",      0, 1, 0, 10'h010, 10'h020, BRF, 9'h005, 0, 0,   0, 10'h000, 1, 0, 8'h05, 1, 0, 16'd2);
    step("brf_we_same", 0, 1, 0, 10'h010, 10'h022, BRF, 9'h005, 1, 1,   0, 10'h000, 1, 0, 8'h05, 1, 0, 16'd3);
    step("brf_taken",   0, 1, 0, 10'h010, 10'h024, BRF, 9'h003, 0, 0,   0, 10'h000, 1, 1, 8'h03, 1, 0, 16'd4);
    step("go_in_run",   0, 1, 1, 10'h100, 10'h027, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'd5);
    step("hlt",         0, 1, 0, 10'h100, 10'h030, HLT, 9'h000, 0, 0,   1, 10'h030, 0, 0, 8'h00, 1, 0, 16'd6);
    step("halt",        0, 1, 0, 10'h000, 10'h030, HLT, 9'h000, 0, 0,   1, 10'h030, 0, 0, 8'h00, 0, 1, 16'd6);
    step("halt_hold",   0, 1, 0, 10'h000, 10'h030, HLT, 9'h000, 0, 0,   1, 10'h030, 0, 0, 8'h00, 0, 1, 16'd6);
    step("halt_go",     0, 1, 1, 10'h000, 10'h030, HLT, 9'h000, 0, 0,   1, 10'h000, 0, 0, 8'h00, 0, 1, 16'd6);
    step("rerun_flag0", 0, 1, 0, 10'h000, 10'h000, BRF, 9'h002, 0, 0,   0, 10'h000, 1, 0, 8'h02, 1, 0, 16'd0);
    step("cnt1",        0, 1, 0, 10'h000, 10'h002, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'd1);
    step("cnt2",        0, 1, 0, 10'h000, 10'h003, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'd2);
    step("cnt3",        0, 1, 0, 10'h000, 10'h004, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'd3);
    step("cnt4",        0, 1, 0, 10'h000, 10'h005, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'd4);
    step("rst_midrun",  0, 0, 0, 10'h010, 10'h006, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'd5);
    step("after_rst",   0, 1, 0, 10'h010, 10'h007, NOP, 9'h000, 0, 0,   1, 10'h010, 0, 0, 8'h00, 0, 0, 16'd0);
    step("go_again",    0, 1, 1, 10'h040, 10'h007, NOP, 9'h000, 0, 0,   1, 10'h040, 0, 0, 8'h00, 0, 0, 16'd0);
    step("sat_fffe",    1, 1, 0, 10'h040, 10'h040, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'hFFFE);
    step("sat_ffff_a",  0, 1, 0, 10'h040, 10'h041, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'hFFFF);
    step("sat_ffff_b",  0, 1, 0, 10'h040, 10'h042, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'hFFFF);
    step("sat_ffff_c",  0, 1, 0, 10'h040, 10'h043, NOP, 9'h000, 0, 0,   0, 10'h000, 0, 0, 8'h00, 1, 0, 16'hFFFF);
    begin
      int waited = 0;
      while (sb_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (sb_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter rom_size, default 512, instruction ROM depth in words.
REQ-002 SHALL have parameter instr_width, default 9, instruction word width (IW).
REQ-003 SHALL have parameter reg_width, default 8, branch offset width (RW). PW = $clog2(rom_size)+1.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 SHALL have port go, input, 1, run request; sampled in IDLE and HALT only.
REQ-007 SHALL have port go_addr, input, PW, program entry address.
REQ-008 SHALL have port pc, input, PW, current program counter value.
REQ-009 SHALL have port instr, input, IW, ROM word at pc.
REQ-010 SHALL have port operand, input, IW, ROM word at pc+1.
REQ-011 SHALL have ports flag_we (input, 1) and flag_d (input, 1), condition-flag write from datapath.
REQ-012 SHALL have ports start (output, 1) and start_addr (output, PW), counter load request.
REQ-013 SHALL have ports branch, taken (outputs, 1) and target (output, signed RW), branch control to counter.
REQ-014 SHALL have ports running, done (outputs, 1) and instr_count (output, 16).

Function
REQ-015 SHALL implement states IDLE, RUN, HALT; encoding free.
REQ-016 IDLE: start=1, start_addr=go_addr, branch=taken=0, running=done=0; go=1 -> RUN.
REQ-017 RUN: start=0, running=1; branch/taken/target decoded combinationally from instr, operand, flag_q.
REQ-018 Decode: instr[IW-1:IW-4]=4'b1101 (BR) -> branch=1, taken=1.
REQ-019 Decode: instr[IW-1:IW-4]=4'b1110 (BRF) -> branch=1, taken=flag_q.
REQ-020 Branch target SHALL be operand[RW-1:0] as signed; offset relative to the address of the branch opcode word. When branch=0, target is 0.
REQ-021 All other opcodes: branch=taken=0. Exception: instr all-ones (HLT).
REQ-022 HLT in RUN: branch=taken=0, start=1, start_addr=pc; halt_pc<=pc; next state HALT.
REQ-023 HALT: start=1, start_addr=halt_pc, done=1, running=0; go=1 -> start_addr=go_addr, next RUN.
REQ-024 flag_q SHALL update from flag_d on flag_we only in RUN. Branches use the registered flag_q only; a same-cycle flag_we does not bypass.
REQ-025 instr_count SHALL increment once per RUN cycle except the HLT cycle, saturating at 16'hFFFF.
REQ-026 A go accepted in IDLE or HALT SHALL clear instr_count and flag_q on that edge.
REQ-027 go SHALL be ignored in RUN. PC wrap-around is the counter's concern; this block applies no range check.
REQ-028 start_addr SHALL never be X; in RUN it is 0 except on the HLT cycle.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, flag_q=0, halt_pc=0, instr_count=0, from any state including mid-RUN.
REQ-030 During and after reset, outputs SHALL follow IDLE: start=1, start_addr=go_addr, branch=taken=running=done=0.

Verification
REQ-031 Reset, go_addr=10'h010, go pulse -> next cycle pc=0x010, running=1, start=0, instr_count=0.
REQ-032 RUN, instr=9'b1101_00000, operand=9'h0FC -> branch=1, taken=1, target=-4; pc 0x010 -> 0x00C next cycle.
REQ-033 RUN, flag_q=0, BRF opcode, operand=9'h005 -> branch=1, taken=0; pc 0x020 -> 0x022. Then flag_we=1, flag_d=1 on the same cycle as a BRF -> taken=0 that cycle, taken=1 on the next BRF.
REQ-034 HLT at pc=0x030 -> start=1, start_addr=0x030 that cycle; then done=1, pc held at 0x030 indefinitely. go=1 with go_addr=0x000 -> RUN from 0x000, instr_count cleared.
REQ-035 rst_n=0 mid-RUN with instr_count=5 -> next cycle IDLE, instr_count=0, start=1.
REQ-036 Force instr_count to 16'hFFFE, then run 3 non-HLT cycles -> instr_count holds 16'hFFFF.
